// File: rtl/demux_1x2_4bit.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x2_4bit
// Purpose  : Steers a tagged word stream into two show-ahead channel FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1x2_4bit #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           a_data,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [$clog2(DEPTH+1)-1:0] a_count,
  output logic [WIDTH-1:0]           b_data,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [$clog2(DEPTH+1)-1:0] b_count
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_full;
  logic [1:0]       w_cons_ready;
  logic [WIDTH-1:0] w_head  [2];
  logic [c_CW-1:0]  w_count [2];

  assign w_cons_ready = {b_ready, a_ready};

  // A full channel only stalls words tagged for it.
  assign in_ready = in_sel ? ~w_full[1] : ~w_full[0];

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;
    logic             w_empty;

    assign w_empty     = (r_count == '0);
    assign w_full[ch]  = (r_count == c_CW'(DEPTH));
    assign w_push[ch]  = in_valid & in_ready & (in_sel == 1'(ch));
    assign w_pop[ch]   = ~w_empty & w_cons_ready[ch];
    assign w_head[ch]  = w_empty ? '0 : r_mem[r_rptr];
    assign w_count[ch] = r_count;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end else begin
        if (w_push[ch]) begin
          r_mem[r_wptr] <= in_data;
          r_wptr        <= r_wptr + c_PW'(1);
        end
        if (w_pop[ch]) begin
          r_rptr <= r_rptr + c_PW'(1);
        end
        // Occupancy is the sole source of full/empty, so pointers may wrap freely.
        case ({w_push[ch], w_pop[ch]})
          2'b10:   r_count <= r_count + c_CW'(1);
          2'b01:   r_count <= r_count - c_CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign a_data  = w_head[0];
  assign a_count = w_count[0];
  assign a_valid = (w_count[0] != '0);
  assign b_data  = w_head[1];
  assign b_count = w_count[1];
  assign b_valid = (w_count[1] != '0);

endmodule
`default_nettype wire

// File: tb/tb_demux_1x2_4bit.sv
`default_nettype none
// Directed-vector bench for demux_1x2_4bit (WIDTH=4, DEPTH=2).
module tb_demux_1x2_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [1:0] a_count;
  logic [3:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [1:0] b_count;

  int checks;
  int errors;

  demux_1x2_4bit #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready), .a_count(a_count),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .b_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [3:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic pop(input logic ch);
    if (ch) b_ready = 1'b1; else a_ready = 1'b1;
    cyc();
    a_ready = 1'b0;
    b_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_data  = 4'h0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_b_count", 32'(b_count), 0);
    chk("rst_a_data",  32'(a_data),  0);
    chk("rst_b_data",  32'(b_data),  0);
    in_sel = 1'b0; #1;
    chk("rst_ready_a", 32'(in_ready), 1);
    in_sel = 1'b1; #1;
    chk("rst_ready_b", 32'(in_ready), 1);

    // Routing
    push(1'b0, 4'b0000);
    push(1'b1, 4'b0011);
    push(1'b0, 4'b1000);
    chk("rt_a_data",  32'(a_data),  32'h0);
    chk("rt_a_count", 32'(a_count), 2);
    chk("rt_a_valid", 32'(a_valid), 1);
    chk("rt_b_data",  32'(b_data),  32'h3);
    chk("rt_b_count", 32'(b_count), 1);
    cyc();
    chk("rt_hold_a",  32'(a_data),  32'h0);
    pop(1'b0);
    chk("rt_pop_a_data",  32'(a_data),  32'h8);
    chk("rt_pop_a_count", 32'(a_count), 1);
    pop(1'b0);
    pop(1'b1);
    chk("rt_empty_a_data", 32'(a_data),  0);
    chk("rt_empty_a_cnt",  32'(a_count), 0);
    chk("rt_empty_b_val",  32'(b_valid), 0);

    // Full / backpressure
    push(1'b0, 4'h5);
    push(1'b0, 4'h6);
    chk("full_a_count", 32'(a_count), 2);
    in_sel = 1'b0; #1;
    chk("full_ready_a", 32'(in_ready), 0);
    in_sel = 1'b1; #1;
    chk("full_ready_b", 32'(in_ready), 1);
    push(1'b0, 4'h7);
    chk("full_rej_count", 32'(a_count), 2);
    chk("full_rej_head",  32'(a_data),  32'h5);
    push(1'b1, 4'h9);
    chk("full_b_count", 32'(b_count), 1);
    chk("full_b_data",  32'(b_data),  32'h9);

    // Full channel: pop and offered push on the same edge
    a_ready  = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 4'h7;
    cyc();
    in_valid = 1'b0;
    a_ready  = 1'b0;
    chk("fullpp_count", 32'(a_count), 1);
    chk("fullpp_head",  32'(a_data),  32'h6);
    pop(1'b0);
    chk("fullpp_drain", 32'(a_count), 0);
    pop(1'b1);
    chk("fullpp_b_drain", 32'(b_count), 0);

    // Push and pop same channel, not full
    push(1'b0, 4'h1);
    a_ready  = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 4'h2;
    cyc();
    in_valid = 1'b0;
    a_ready  = 1'b0;
    chk("pp_count", 32'(a_count), 1);
    chk("pp_head",  32'(a_data),  32'h2);
    pop(1'b0);
    chk("pp_drain", 32'(a_count), 0);

    // Streaming through pointer wrap
    a_ready  = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i);
      cyc();
      chk("stream_data",  32'(a_data),  32'(i));
      chk("stream_valid", 32'(a_valid), 1);
      chk("stream_count", 32'(a_count), 1);
    end
    in_valid = 1'b0;
    cyc();
    a_ready = 1'b0;
    chk("stream_end_count", 32'(a_count), 0);

    // Reset mid-operation
    push(1'b0, 4'h3);
    push(1'b0, 4'h4);
    push(1'b1, 4'h5);
    chk("mid_pre_a", 32'(a_count), 2);
    chk("mid_pre_b", 32'(b_count), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_a_count", 32'(a_count), 0);
    chk("mid_b_count", 32'(b_count), 0);
    chk("mid_a_valid", 32'(a_valid), 0);
    chk("mid_b_valid", 32'(b_valid), 0);
    chk("mid_a_data",  32'(a_data),  0);
    push(1'b0, 4'hC);
    push(1'b1, 4'hD);
    chk("post_a_data",  32'(a_data),  32'hC);
    chk("post_a_count", 32'(a_count), 1);
    chk("post_b_data",  32'(b_data),  32'hD);
    pop(1'b0);
    chk("post_a_empty", 32'(a_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_1x2_4bit.md
Name: demux_1x2_4bit

Overview:
- Receive-side counterpart of the 2x1 4-bit mux: takes one tagged word stream and steers each word to channel a or channel b by its select bit.
- Each channel has a small show-ahead FIFO with valid/ready handshakes on both sides. The two consumers can therefore drain at independent rates.
- Sits at the far end of a shared 4-bit link. It restores the two streams that an upstream mux combined.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 2, entries per channel FIFO. Must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word from the shared link.
- in_sel  input  1  destination tag: 0 routes to channel a, 1 routes to channel b.
- in_valid  input  1  in_data and in_sel are valid this cycle.
- in_ready  output  1  the destination selected by in_sel can accept a word.
- a_data  output  WIDTH  head word of the channel-a FIFO.
- a_valid  output  1  channel-a FIFO is not empty.
- a_ready  input  1  channel-a consumer takes the head word.
- a_count  output  $clog2(DEPTH+1)  channel-a occupancy.
- b_data  output  WIDTH  head word of the channel-b FIFO.
- b_valid  output  1  channel-b FIFO is not empty.
- b_ready  input  1  channel-b consumer takes the head word.
- b_count  output  $clog2(DEPTH+1)  channel-b occupancy.

Behaviour:
- Reset, while rst=1 at a rising edge:
  - both FIFOs are emptied, with pointers and counts set to 0;
  - a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0;
  - in_ready goes to 1 for the cycle after reset is released.
  - Reset asserted mid-operation discards all buffered words. No handshake completes on that edge.
- in_ready:
  - combinational: in_ready = (in_sel ? ~b_full : ~a_full).
  - It does not depend on in_valid.
  - A full channel blocks only words tagged for it; the other channel keeps accepting.
- Push: a push happens on an edge where in_valid && in_ready. The word is written to the FIFO selected by in_sel and that count increments.
- Pop:
  - channel a pops on an edge where a_valid && a_ready; channel b likewise with b_valid && b_ready;
  - the read pointer advances and the count decrements.
- Show-ahead outputs:
  - x_data always shows the oldest unpopped entry, and is 0 when the FIFO is empty;
  - x_valid = (x_count != 0).
- Latency: a word accepted at edge k appears on x_data with x_valid=1 immediately after edge k. There is no combinational bypass from input to output.
- Ordering: FIFO order is preserved within each channel. There is no ordering relation between channels.
- Simultaneous push and pop on the same channel:
  - if the channel is not full, both happen and the count is unchanged;
  - if the channel is full, in_ready=0 for that tag, so no push occurs even when a pop happens that cycle. Full blocks for one cycle with no pass-through.
- Simultaneous push to one channel and pop from the other: fully independent.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are taken from the count, not from pointer comparison.
- Output holding: outputs are held while x_valid=1 and x_ready=0. x_data must not change until the pop.
- in_ready low: words offered while in_ready=0 are not consumed. The producer holds them, which is the upstream's responsibility.
- Invariants: counts never exceed DEPTH and never underflow. A pop while empty and a push while full are impossible by construction.

Test Plan:
- Reset and idle:
  - drive rst=1 for 2 cycles, then release;
  - required: a_valid=b_valid=0, counts=0, a_data=b_data=0;
  - required: in_ready=1 for in_sel=0 and for in_sel=1.
- Routing:
  - push 4'b0000 with sel=0, then 4'b0011 with sel=1, then 4'b1000 with sel=0; hold a_ready=b_ready=0;
  - required: a_data=0000 and a_count=2; b_data=0011 and b_count=1;
  - required: pop a, then a_data=1000.
- Full/backpressure:
  - push 4'h5 and 4'h6 to channel a with a_ready=0;
  - required: a_count=2 and in_ready=0 with sel=0, while in_ready=1 with sel=1;
  - a third word 4'h7 offered to channel a is not accepted; 4'h9 pushed to channel b is accepted.
- Simultaneous events:
  - with a_count=1 (head 4'h1), push 4'h2 to a and pop a on the same edge: required a_count=1, a_data=2;
  - with a full, assert a_ready and offer a word to a on the same edge: required no push, a_count becomes 1.
- Wrap and streaming:
  - hold a_ready=1 and stream 4'h0..4'hF to channel a, one per cycle;
  - required: a_data sequence 0..F in order, one cycle after each accept; pointers wrap 8 times; no loss.
- Reset mid-operation:
  - with a_count=2 and b_count=1, assert rst for 1 cycle;
  - required: all counts and valids 0 on the next cycle; earlier words never reappear after new pushes.
